ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle CPU. Owns the program counter, drives the instruction-memory address, and waits a configurable number of cycles for the combinational instruction memory to settle.
- Captures the returned word into the instruction register (IR) and signals the main controller with a one-cycle valid pulse.
- Computes the next PC from the controller's selection: sequential, branch, jump or register jump.

Parameters:
- TEXT_BASE, 32'h0000_3000, reset PC and first byte of the text segment.
- TEXT_WORDS, 128, number of instruction words in the text segment; fetches at or beyond it fault.
- MEM_WAIT, 0, extra wait cycles before the IR capture edge. Legal range 0..7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- fetch_req  input  1  controller requests a fetch at the current PC.
- pc_write  input  1  load next PC at this edge.
- npc_sel  input  2  next-PC source: 00 = PC+4, 01 = branch_target, 10 = jump, 11 = jr_target.
- branch_target  input  32  precomputed branch address.
- jump_index  input  26  J-type index field.
- jr_target  input  32  register value for jr.
- im_addr  output  32  byte address to instruction memory.
- im_dout  input  32  instruction word from memory.
- ir  output  32  instruction register.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, combinational.
- ins_valid  output  1  one-cycle pulse: IR holds the new instruction.
- fetch_busy  output  1  high in WAIT and DONE.
- addr_fault  output  1  sticky misaligned or out-of-range fetch flag.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = TEXT_BASE, ir = 0, state = IDLE, wait counter = 0, ins_valid = 0, addr_fault = 0.
  - A fetch in progress is aborted and the IR is not written.
- Outputs:
  - im_addr = pc at all times.
  - pc_plus4 = pc + 32'd4, modulo 2^32; wrap is not flagged.
- FSM states: IDLE, WAIT, DONE.
  - fetch_busy = (state != IDLE).
  - ins_valid = (state == DONE).
- IDLE:
  - fetch_req = 1 and the PC is legal: go to WAIT and load the counter with MEM_WAIT.
  - fetch_req = 1 and the PC is illegal: set addr_fault, stay in IDLE, leave the IR unchanged.
  - PC is legal when pc[1:0] == 0 and (pc - TEXT_BASE) < TEXT_WORDS*4. The compare is unsigned 32-bit, so a pc below TEXT_BASE wraps to a large value and faults.
- WAIT:
  - counter != 0: decrement the counter.
  - counter == 0: ir <= im_dout at this edge, then go to DONE.
- DONE: lasts exactly one cycle (ins_valid = 1), then returns to IDLE.
  - fetch_req in DONE is ignored.
  - The controller re-requests the next fetch from IDLE.
- Latency: fetch_req sampled at edge k, IR written at edge k+1+MEM_WAIT, ins_valid high during the following cycle.
  - Back-to-back fetches start at best every MEM_WAIT+3 cycles.
- PC update, in IDLE or DONE only: pc_write = 1 loads the next PC at the edge.
  - 00: pc_plus4.
  - 01: branch_target.
  - 10: {pc_plus4[31:28], jump_index, 2'b00}.
  - 11: jr_target.
  - In WAIT, pc_write is ignored so that im_addr stays stable while the fetch is in flight.
- fetch_req and pc_write in the same IDLE cycle: the PC updates at that edge and the fetch uses the NEW PC.
  - Legality is checked against the NEW PC; the fault is raised at the next edge and the FSM stays in IDLE.
- Targets are loaded unchecked; alignment is only checked at fetch time.
- addr_fault is cleared only by reset.
  - While it is set, fetch_req is ignored: state stays IDLE and the IR is frozen.
  - PC updates still occur while it is set.

Test Plan:
1. Reset then release, MEM_WAIT = 0, memory holds 32'h2008_0005 at 0x3000. Pulse fetch_req → ir = 32'h2008_0005 after 1 edge, ins_valid high for exactly 1 cycle, pc = 0x3000, pc_plus4 = 0x3004.
2. MEM_WAIT = 3, fetch_req at edge k → fetch_busy high for 5 cycles, IR written at edge k+4, ins_valid during the cycle after. pc_write asserted in WAIT leaves pc unchanged.
3. Next-PC sources from pc = 0x3010:
   - npc_sel = 00 → 0x3014.
   - npc_sel = 01 with branch_target = 0x3040 → 0x3040.
   - npc_sel = 10 with jump_index = 26'h0000C08 → 0x0000_3020.
   - npc_sel = 11 with jr_target = 0x3008 → 0x3008.
4. Same-cycle pc_write (npc_sel = 01, target 0x3100) and fetch_req → fetch reads 0x3100, and the IR gets the word at 0x3100.
5. Faults, each checked after a reset:
   - jr_target = 0x3002 then fetch → addr_fault = 1, IR unchanged, no ins_valid.
   - pc = 0x3200 (word 128) then fetch → addr_fault = 1.
   - pc = 0x2FFC then fetch → addr_fault = 1.
   - After any fault, further fetch_req is ignored until reset.
6. Assert rst low during WAIT (MEM_WAIT = 5) → immediately pc = 0x3000, ir = 0, fetch_busy = 0, ins_valid = 0. After release, a fresh fetch works normally.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage of the multi-cycle CPU.
// Owns the program counter and presents it to a combinational instruction
// memory. After a programmable settle time it captures the returned word
// into the instruction register and pulses ins_valid for one cycle.
// It also selects the next PC for the controller: sequential, branch,
// jump or register jump.
module ifetch_unit #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter int unsigned TEXT_WORDS = 128,
  parameter int unsigned MEM_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ins_valid,
  output logic        fetch_busy,
  output logic        addr_fault
);

  // Size of the text segment in bytes, used by the range check.
  localparam logic [31:0] TEXT_BYTES = 32'(TEXT_WORDS * 4);
  // Initial value of the wait counter; the counter is 3 bits wide
  // because MEM_WAIT only goes up to 7.
  localparam logic [2:0]  WAIT_INIT  = 3'(MEM_WAIT);

  // Encodings for the next-PC source select.
  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        fault_q;

  logic [31:0] seq_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;
  logic        pc_load;
  logic [31:0] fetch_pc;
  logic        fetch_ok;
  logic        fetch_start;
  logic        fetch_reject;

  // A fetch address is usable when it is word aligned and lies inside the
  // text segment. The offset is computed modulo 2^32, so an address below
  // TEXT_BASE wraps to a huge offset and is rejected by the same compare.
  function automatic logic pc_legal(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - TEXT_BASE;
    return (addr[1:0] == 2'b00) && (offset < TEXT_BYTES);
  endfunction

  // J-type target: the upper nibble comes from the sequential PC and the
  // index is shifted up by two to form a word address.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc4,
                                            input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

  // Sequential and jump candidates come from the current PC.
  assign seq_pc  = pc_q + 32'd4;
  assign jump_pc = jump_addr(seq_pc, jump_index);

  // Next-PC multiplexer driven by the controller's select.
  always_comb begin
    next_pc = seq_pc;
    unique case (npc_sel)
      NPC_SEQ:    next_pc = seq_pc;
      NPC_BRANCH: next_pc = branch_target;
      NPC_JUMP:   next_pc = jump_pc;
      NPC_JR:     next_pc = jr_target;
      default:    next_pc = seq_pc;
    endcase
  end

  // The PC may only move while no fetch is in flight, so that im_addr
  // stays stable for the whole memory settle time.
  assign pc_load = pc_write && (state != WAIT);

  // A fetch requested in the same cycle as a PC load targets the new PC,
  // so legality is judged on the value the PC is about to take.
  assign fetch_pc = pc_load ? next_pc : pc_q;
  assign fetch_ok = pc_legal(fetch_pc);

  // Fetch requests are honoured only in IDLE and only while no fault is
  // latched; a latched fault freezes the fetch path until reset.
  assign fetch_start  = (state == IDLE) && fetch_req && !fault_q && fetch_ok;
  assign fetch_reject = (state == IDLE) && fetch_req && !fault_q && !fetch_ok;

  // Program counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= TEXT_BASE;
    end else if (pc_load) begin
      pc_q <= next_pc;
    end
  end

  // Fetch sequencer: start, settle countdown, IR capture, valid cycle.
  // The sticky fault flag and the IR are updated here as well.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      ir_q     <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_start) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end else if (fetch_reject) begin
            fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            ir_q  <= im_dout;
            state <= DONE;
          end
        end
        DONE: begin
          // Requests seen here are dropped; the controller asks again
          // once the unit is back in IDLE.
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign im_addr    = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = seq_pc;
  assign ir         = ir_q;
  assign ins_valid  = (state == DONE);
  assign fetch_busy = (state != IDLE);
  assign addr_fault = fault_q;

endmodule
